// File: rtl/seg_pkg.sv
// Shared types and helpers for the motor PWM driver: counter width, duty
// limit, channel FSM / desired-drive encodings and symmetric saturation.
package seg_pkg;

  localparam int          PWM_W    = 11;
  localparam logic [10:0] DUTY_MAX = 11'd2047;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEAD   = 2'd1,
    FWD_ON = 2'd2,
    REV_ON = 2'd3
  } chan_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } desire_t;

  // Clamp a 14-bit signed sum into [-2047, +2047]; -2048 is never returned
  // so the magnitude always fits in 11 bits.
  function automatic logic signed [11:0] sat12sym(input logic signed [13:0] v);
    logic signed [11:0] r;
    if (v > 14'sd2047) begin
      r = 12'sd2047;
    end else if (v < -14'sd2047) begin
      r = -12'sd2047;
    end else begin
      r = v[11:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mtr_pwm_drv_hbridge_chan.sv
// One H-bridge channel: compares the shadow duty against the PWM counter and
// runs a dead-time FSM so that every rising output is preceded by DEAD_CYC
// cycles with both bridge legs off. Outputs are registered.
module hbridge_chan
  import seg_pkg::*;
#(
  parameter int DEAD_CYC = 32,
  parameter int CNT_W    = PWM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  input  logic             dir,
  input  logic             force_off,
  output logic             fwd,
  output logic             rev
);

  localparam logic [7:0] DEAD_LD = 8'(DEAD_CYC - 1);

  desire_t     desire_s;
  chan_state_t state_r;
  chan_state_t state_s;
  logic [7:0]  dcnt_r;
  logic [7:0]  dcnt_s;

  // Desired drive for the current counter position
  always_comb begin
    desire_s = NONE;
    if ((duty == {CNT_W{1'b0}}) || (cnt >= duty)) begin
      desire_s = NONE;
    end else if (dir) begin
      desire_s = REV;
    end else begin
      desire_s = FWD;
    end
  end

  // Next-state logic: every rise passes through DEAD, every fall is immediate
  always_comb begin
    state_s = state_r;
    dcnt_s  = dcnt_r;
    if (force_off) begin
      state_s = IDLE;
      dcnt_s  = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (desire_s != NONE) begin
            state_s = DEAD;
            dcnt_s  = DEAD_LD;
          end else begin
            state_s = IDLE;
          end
        end
        DEAD: begin
          if (dcnt_r == 8'd0) begin
            case (desire_s)
              FWD:     state_s = FWD_ON;
              REV:     state_s = REV_ON;
              default: state_s = IDLE;
            endcase
          end else begin
            dcnt_s = dcnt_r - 8'd1;
          end
        end
        FWD_ON: begin
          if (desire_s != FWD) begin
            state_s = DEAD;
            dcnt_s  = DEAD_LD;
          end else begin
            state_s = FWD_ON;
          end
        end
        REV_ON: begin
          if (desire_s != REV) begin
            state_s = DEAD;
            dcnt_s  = DEAD_LD;
          end else begin
            state_s = REV_ON;
          end
        end
        default: begin
          state_s = IDLE;
          dcnt_s  = 8'd0;
        end
      endcase
    end
  end

  // State, dead-time counter and decoded bridge outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      dcnt_r  <= 8'd0;
      fwd     <= 1'b0;
      rev     <= 1'b0;
    end else begin
      state_r <= state_s;
      dcnt_r  <= dcnt_s;
      fwd     <= (state_s == FWD_ON);
      rev     <= (state_s == REV_ON);
    end
  end

endmodule

// File: rtl/mtr_pwm_drv.sv
// Motor PWM driver top: scales the PID command by the soft-start timer, adds
// and subtracts steering, saturates, latches per-period shadow duty/direction
// and drives two dead-time-protected H-bridge channels.
// Optional build macro SEG_OVR_I_EN adds cycle-by-cycle over-current blanking
// (input ovr_i) and a saturating blanked-period counter (output ovr_cnt).
module mtr_pwm_drv #(
  parameter int DEAD_CYC = 32,
  parameter int PWM_W    = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic [11:0] PID_cntrl,
  input  logic [7:0]  ss_tmr,
  input  logic [11:0] steer,
  output logic        lft_fwd,
  output logic        lft_rev,
  output logic        rght_fwd,
  output logic        rght_rev,
`ifdef SEG_OVR_I_EN
  input  logic        ovr_i,
  output logic [7:0]  ovr_cnt,
`endif
  output logic        prd_strt
);

  import seg_pkg::sat12sym;

  logic [PWM_W-1:0]   cnt_r;
  logic               wrap_s;
  logic signed [19:0] prod_s;
  logic signed [19:0] shr_s;
  logic signed [11:0] scaled_s;
  logic signed [13:0] lft_sum_s;
  logic signed [13:0] rght_sum_s;
  logic signed [11:0] lft_val_s;
  logic signed [11:0] rght_val_s;
  logic [11:0]        lft_neg_s;
  logic [11:0]        rght_neg_s;
  logic [10:0]        lft_mag_s;
  logic [10:0]        rght_mag_s;
  logic [PWM_W-1:0]   lft_duty_r;
  logic [PWM_W-1:0]   rght_duty_r;
  logic               lft_dir_r;
  logic               rght_dir_r;
  logic               force_s;

  assign wrap_s = &cnt_r;

  // Free-running PWM counter and registered period-start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {PWM_W{1'b0}};
      prd_strt <= 1'b0;
    end else begin
      cnt_r    <= cnt_r + {{(PWM_W-1){1'b0}}, 1'b1};
      prd_strt <= wrap_s;
    end
  end

  // Soft-start scaling, steering mix, saturation and sign/magnitude split
  always_comb begin
    prod_s     = $signed({{8{PID_cntrl[11]}}, PID_cntrl}) * $signed({11'd0, ss_tmr});
    shr_s      = prod_s >>> 4'd8;
    scaled_s   = shr_s[11:0];
    lft_sum_s  = $signed({{2{scaled_s[11]}}, scaled_s}) + $signed({{2{steer[11]}}, steer});
    rght_sum_s = $signed({{2{scaled_s[11]}}, scaled_s}) - $signed({{2{steer[11]}}, steer});
    lft_val_s  = sat12sym(lft_sum_s);
    rght_val_s = sat12sym(rght_sum_s);
    lft_neg_s  = 12'd0 - lft_val_s;
    rght_neg_s = 12'd0 - rght_val_s;
    if (lft_val_s[11]) begin
      lft_mag_s = lft_neg_s[10:0];
    end else begin
      lft_mag_s = lft_val_s[10:0];
    end
    if (rght_val_s[11]) begin
      rght_mag_s = rght_neg_s[10:0];
    end else begin
      rght_mag_s = rght_val_s[10:0];
    end
  end

  // Shadow duty/direction: loaded only at the end of a period, cleared when off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_duty_r  <= {PWM_W{1'b0}};
      rght_duty_r <= {PWM_W{1'b0}};
      lft_dir_r   <= 1'b0;
      rght_dir_r  <= 1'b0;
    end else if (!pwr_up) begin
      lft_duty_r  <= {PWM_W{1'b0}};
      rght_duty_r <= {PWM_W{1'b0}};
      lft_dir_r   <= 1'b0;
      rght_dir_r  <= 1'b0;
    end else if (wrap_s) begin
      lft_duty_r  <= PWM_W'(lft_mag_s);
      rght_duty_r <= PWM_W'(rght_mag_s);
      lft_dir_r   <= lft_val_s[11];
      rght_dir_r  <= rght_val_s[11];
    end
  end

`ifdef SEG_OVR_I_EN
  logic blank_r;

  // Over-current blank holds until the period wraps; count blanked periods
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_r <= 1'b0;
      ovr_cnt <= 8'd0;
    end else begin
      if (wrap_s) begin
        blank_r <= 1'b0;
      end else if (ovr_i) begin
        blank_r <= 1'b1;
      end
      if (ovr_i && !blank_r && (ovr_cnt != 8'hFF)) begin
        ovr_cnt <= ovr_cnt + 8'd1;
      end
    end
  end

  assign force_s = (~pwr_up) | ovr_i | blank_r;
`else
  assign force_s = ~pwr_up;
`endif

  hbridge_chan #(
    .DEAD_CYC (DEAD_CYC),
    .CNT_W    (PWM_W)
  ) u_lft (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (cnt_r),
    .duty      (lft_duty_r),
    .dir       (lft_dir_r),
    .force_off (force_s),
    .fwd       (lft_fwd),
    .rev       (lft_rev)
  );

  hbridge_chan #(
    .DEAD_CYC (DEAD_CYC),
    .CNT_W    (PWM_W)
  ) u_rght (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (cnt_r),
    .duty      (rght_duty_r),
    .dir       (rght_dir_r),
    .force_off (force_s),
    .fwd       (rght_fwd),
    .rev       (rght_rev)
  );

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Directed self-checking bench for mtr_pwm_drv. Each period is captured from
// prd_strt onward (index = cnt value) and the first/last/count of high cycles
// per output is compared against hand-computed values.
module tb_mtr_pwm_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwr_up;
  logic [11:0] PID_cntrl;
  logic [7:0]  ss_tmr;
  logic [11:0] steer;
  logic        lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt;
`ifdef SEG_OVR_I_EN
  logic        ovr_i = 1'b0;
  logic [7:0]  ovr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // per-period capture: index 0 lft_fwd, 1 lft_rev, 2 rght_fwd, 3 rght_rev
  int m_first[4];
  int m_last[4];
  int m_cnt[4];
  int m_ovl;
  int m_ps;

  mtr_pwm_drv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_up    (pwr_up),
    .PID_cntrl (PID_cntrl),
    .ss_tmr    (ss_tmr),
    .steer     (steer),
    .lft_fwd   (lft_fwd),
    .lft_rev   (lft_rev),
    .rght_fwd  (rght_fwd),
    .rght_rev  (rght_rev),
`ifdef SEG_OVR_I_EN
    .ovr_i     (ovr_i),
    .ovr_cnt   (ovr_cnt),
`endif
    .prd_strt  (prd_strt)
  );

  always #5 clk = ~clk;

  // advance to the next negedge where prd_strt is high (cnt==0)
  task automatic sync_period();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!prd_strt && n < 2100);
    total++;
    if (prd_strt !== 1'b1) begin
      bad++;
      $display("FAIL sync_timeout: prd_strt=%b after %0d cycles, required 1", prd_strt, n);
    end
  endtask

  // capture one full period; optional mid-period PID change and pwr_up drop/restore
  task automatic measure(input int chg_idx, input logic [11:0] chg_pid,
                         input int off_idx, input int on_idx);
    logic [3:0] o;
    for (int k = 0; k < 4; k++) begin
      m_first[k] = -1;
      m_last[k]  = -1;
      m_cnt[k]   = 0;
    end
    m_ovl = 0;
    m_ps  = 0;
    sync_period();
    for (int i = 0; i < 2048; i++) begin
      if (i > 0) @(negedge clk);
      o = {rght_rev, rght_fwd, lft_rev, lft_fwd};
      for (int k = 0; k < 4; k++) begin
        if (o[k]) begin
          if (m_first[k] < 0) m_first[k] = i;
          m_last[k] = i;
          m_cnt[k]++;
        end
      end
      if ((lft_fwd & lft_rev) | (rght_fwd & rght_rev)) m_ovl++;
      if (i > 0 && prd_strt) m_ps++;
      if (i == chg_idx) PID_cntrl = chg_pid;
      if (i == off_idx) pwr_up = 1'b0;
      if (i == on_idx)  pwr_up = 1'b1;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; pwr_up = 1'b0; PID_cntrl = 12'd0; ss_tmr = 8'd0; steer = 12'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt});
    end
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!prd_strt && n < 2100);
    total++;
    if (n !== 2048) begin
      bad++;
      $display("FAIL first_prd_strt: seen after %0d cycles, required 2048", n);
    end
  endtask

  task automatic test_straight();
    int ef[4] = '{33, -1, 33, -1};
    int el[4] = '{398, -1, 398, -1};
    int ec[4] = '{366, 0, 366, 0};
    pwr_up = 1'b1; PID_cntrl = 12'd400; ss_tmr = 8'd255; steer = 12'd0;
    measure(-1, 12'd0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (m_first[k] !== ef[k] || m_last[k] !== el[k] || m_cnt[k] !== ec[k]) begin
        bad++;
        $display("FAIL straight ch%0d: first/last/count=%0d/%0d/%0d, required %0d/%0d/%0d",
                 k, m_first[k], m_last[k], m_cnt[k], ef[k], el[k], ec[k]);
      end
    end
    total++;
    if (m_ps !== 0) begin
      bad++;
      $display("FAIL prd_strt_extra: %0d extra pulses in period, required 0", m_ps);
    end
  endtask

  task automatic test_steer();
    int ef[4] = '{33, -1, 33, -1};
    int el[4] = '{498, -1, 298, -1};
    int ec[4] = '{466, 0, 266, 0};
    steer = 12'd100;
    measure(-1, 12'd0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (m_first[k] !== ef[k] || m_last[k] !== el[k] || m_cnt[k] !== ec[k]) begin
        bad++;
        $display("FAIL steer ch%0d: first/last/count=%0d/%0d/%0d, required %0d/%0d/%0d",
                 k, m_first[k], m_last[k], m_cnt[k], ef[k], el[k], ec[k]);
      end
    end
  endtask

  task automatic test_reversal();
    // +300*255>>>8 = 298; -300*255>>>8 = -299 (arithmetic shift floors)
    int ef[4] = '{33, -1, 33, -1};
    int el[4] = '{298, -1, 298, -1};
    int ec[4] = '{266, 0, 266, 0};
    int rf[4] = '{-1, 33, -1, 33};
    int rl[4] = '{-1, 299, -1, 299};
    int rc[4] = '{0, 267, 0, 267};
    steer = 12'd0; PID_cntrl = 12'd300;
    measure(-1, 12'd0, -1, -1);
    measure(1000, 12'hED4, -1, -1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (m_first[k] !== ef[k] || m_last[k] !== el[k] || m_cnt[k] !== ec[k]) begin
        bad++;
        $display("FAIL rev_midperiod ch%0d: first/last/count=%0d/%0d/%0d, required %0d/%0d/%0d",
                 k, m_first[k], m_last[k], m_cnt[k], ef[k], el[k], ec[k]);
      end
    end
    measure(-1, 12'd0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (m_first[k] !== rf[k] || m_last[k] !== rl[k] || m_cnt[k] !== rc[k]) begin
        bad++;
        $display("FAIL rev_next ch%0d: first/last/count=%0d/%0d/%0d, required %0d/%0d/%0d",
                 k, m_first[k], m_last[k], m_cnt[k], rf[k], rl[k], rc[k]);
      end
    end
    total++;
    if (m_ovl !== 0) begin
      bad++;
      $display("FAIL rev_overlap: %0d cycles with fwd&rev, required 0", m_ovl);
    end
  endtask

  task automatic test_saturate();
    // lft saturates to 2047; rght = 2039-2047 = -8, below dead time
    int ef[4] = '{33, -1, -1, -1};
    int el[4] = '{2047, -1, -1, -1};
    int ec[4] = '{2015, 0, 0, 0};
    int sf[4] = '{32, -1, -1, -1};
    int sc[4] = '{2016, 0, 0, 0};
    PID_cntrl = 12'd2047; steer = 12'd2047;
    measure(-1, 12'd0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (m_first[k] !== ef[k] || m_last[k] !== el[k] || m_cnt[k] !== ec[k]) begin
        bad++;
        $display("FAIL sat_first ch%0d: first/last/count=%0d/%0d/%0d, required %0d/%0d/%0d",
                 k, m_first[k], m_last[k], m_cnt[k], ef[k], el[k], ec[k]);
      end
    end
    measure(-1, 12'd0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (m_first[k] !== sf[k] || m_last[k] !== el[k] || m_cnt[k] !== sc[k]) begin
        bad++;
        $display("FAIL sat_steady ch%0d: first/last/count=%0d/%0d/%0d, required %0d/%0d/%0d",
                 k, m_first[k], m_last[k], m_cnt[k], sf[k], el[k], sc[k]);
      end
    end
  endtask

  task automatic test_small_duty();
    PID_cntrl = 12'd20; steer = 12'd0;
    measure(-1, 12'd0, -1, -1);
    total++;
    if ((m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3]) !== 0) begin
      bad++;
      $display("FAIL small_duty: high cycles %0d/%0d/%0d/%0d, required all 0",
               m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
    end
  endtask

  task automatic test_dead_boundary();
    int ef[4] = '{33, -1, -1, 33};
    int ec[4] = '{1, 0, 0, 1};
    // soft-start zero: only steer drives; duty 32 equals dead time
    ss_tmr = 8'd0; PID_cntrl = 12'd400; steer = 12'd32;
    measure(-1, 12'd0, -1, -1);
    total++;
    if ((m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3]) !== 0) begin
      bad++;
      $display("FAIL duty_eq_dead: high cycles %0d/%0d/%0d/%0d, required all 0",
               m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
    end
    steer = 12'd33;
    measure(-1, 12'd0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (m_first[k] !== ef[k] || m_last[k] !== ef[k] || m_cnt[k] !== ec[k]) begin
        bad++;
        $display("FAIL duty_dead_p1 ch%0d: first/last/count=%0d/%0d/%0d, required %0d/%0d/%0d",
                 k, m_first[k], m_last[k], m_cnt[k], ef[k], ef[k], ec[k]);
      end
    end
  endtask

  task automatic test_pwr_up();
    int ef[4] = '{33, -1, 33, -1};
    int el[4] = '{200, -1, 200, -1};
    int ec[4] = '{168, 0, 168, 0};
    int nl[4] = '{398, -1, 398, -1};
    int nc[4] = '{366, 0, 366, 0};
    ss_tmr = 8'd255; PID_cntrl = 12'd400; steer = 12'd0;
    measure(-1, 12'd0, -1, -1);
    measure(-1, 12'd0, 200, 500);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (m_first[k] !== ef[k] || m_last[k] !== el[k] || m_cnt[k] !== ec[k]) begin
        bad++;
        $display("FAIL pwr_drop ch%0d: first/last/count=%0d/%0d/%0d, required %0d/%0d/%0d",
                 k, m_first[k], m_last[k], m_cnt[k], ef[k], el[k], ec[k]);
      end
    end
    measure(-1, 12'd0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (m_first[k] !== ef[k] || m_last[k] !== nl[k] || m_cnt[k] !== nc[k]) begin
        bad++;
        $display("FAIL pwr_resume ch%0d: first/last/count=%0d/%0d/%0d, required %0d/%0d/%0d",
                 k, m_first[k], m_last[k], m_cnt[k], ef[k], nl[k], nc[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    sync_period();
    repeat (100) @(negedge clk);
    total++;
    if ({lft_fwd, rght_fwd} !== 2'b11) begin
      bad++;
      $display("FAIL pre_reset_drive: fwd=%b, required 11", {lft_fwd, rght_fwd});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt} !== 5'b00000) begin
      bad++;
      $display("FAIL async_reset: got %b, required 00000",
               {lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_steer();
    test_reversal();
    test_saturate();
    test_small_duty();
    test_dead_boundary();
    test_pwr_up();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
